base_tdec_trk: RTL and testbench

Level tracker that holds a saturating level in the range 0..dec_width and reports it as a thermometer code (MSB-first: 0=000.., 1=100.., 2=110..). It is the decode-side counterpart of the thermometer encoder. It accepts load/inc/dec/clear commands over a valid/ready input and emits one thermometer-coded result beat per accepted command over a valid/ready output. It is used for credit masks and fill-level vectors feeding priority and mux logic.

---
 rtl/base_tdec_pkg.sv | 14 +
 rtl/base_tdec_trk_tdec.sv | 20 ++
 rtl/base_tdec_trk.sv | 133 +++++++++++++
 tb/tb_base_tdec_trk.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/base_tdec_pkg.sv
// Shared types and constants for the thermometer level tracker.
// Command encoding and output queue depth.
package base_tdec_pkg;

  typedef enum logic [1:0] {
    TDEC_LOAD = 2'b00,
    TDEC_INC  = 2'b01,
    TDEC_DEC  = 2'b10,
    TDEC_CLR  = 2'b11
  } tdec_op_e;

  localparam int TDEC_DEPTH = 2;

endpackage

// File: rtl/base_tdec_trk_tdec.sv
// Binary to thermometer decoder, MSB-first.
// Bit j (0 = MSB) is set when j < i_d.
module base_tdec
  import base_tdec_pkg::*;
#(
  parameter int dec_width = 8,
  parameter int enc_width = 4
) (
  input  logic [0:enc_width-1] i_d,
  output logic [0:dec_width-1] o_d
);

  always_comb begin
    o_d = '0;
    for (int j = 0; j < dec_width; j++) begin
      o_d[j] = (i_d > enc_width'(j));
    end
  end

endmodule

// File: rtl/base_tdec_trk.sv
// Saturating level tracker with thermometer-coded result queue.
// Commands update the level; each accept pushes one result beat.
module base_tdec_trk
  import base_tdec_pkg::*;
#(
  parameter int dec_width = 8,
  parameter int enc_width = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_v,
  output logic                 i_r,
  input  logic [1:0]           i_op,
  input  logic [enc_width-1:0] i_d,
  output logic                 o_v,
  input  logic                 o_r,
  output logic [dec_width-1:0] o_d,
  output logic [enc_width-1:0] o_cnt,
  output logic                 o_sat,
  output logic                 o_err
);

  generate
    if (enc_width < $clog2(dec_width + 1)) begin : g_chk
      $error("enc_width too small for dec_width");
    end
  endgenerate

  localparam logic [enc_width:0] TOP =
    (enc_width + 1)'(dec_width);
  localparam logic [1:0] FULL = 2'(TDEC_DEPTH);

  logic [enc_width-1:0] lvl;
  logic [enc_width-1:0] lvl_new;
  logic                 sat;
  logic                 clr;
  logic                 push;
  logic                 pop;
  tdec_op_e             op;
  logic [0:dec_width-1] therm;

  logic [dec_width-1:0] q_d   [TDEC_DEPTH];
  logic [enc_width-1:0] q_cnt [TDEC_DEPTH];
  logic                 q_sat [TDEC_DEPTH];
  logic                 wp;
  logic                 rp;
  logic [1:0]           cnt;
  logic [1:0]           cnt_nxt;

  assign op   = tdec_op_e'(i_op);
  assign push = i_v & i_r;
  assign pop  = o_v & o_r;

  // Compares run one bit wider so the top level never wraps.
  always_comb begin
    lvl_new = lvl;
    sat     = 1'b0;
    clr     = 1'b0;
    unique case (op)
      TDEC_LOAD: begin
        if ({1'b0, i_d} > TOP) begin
          lvl_new = enc_width'(dec_width);
          sat     = 1'b1;
        end else begin
          lvl_new = i_d;
        end
      end
      TDEC_INC: begin
        if ({1'b0, lvl} == TOP) sat = 1'b1;
        else lvl_new = lvl + enc_width'(1);
      end
      TDEC_DEC: begin
        if (lvl == '0) sat = 1'b1;
        else lvl_new = lvl - enc_width'(1);
      end
      TDEC_CLR: begin
        lvl_new = '0;
        clr     = 1'b1;
      end
      default: ;
    endcase
  end

  base_tdec #(
    .dec_width(dec_width),
    .enc_width(enc_width)
  ) u_tdec (
    .i_d(lvl_new),
    .o_d(therm)
  );

  always_comb begin
    cnt_nxt = cnt;
    if (push & ~pop) cnt_nxt = cnt + 2'd1;
    else if (~push & pop) cnt_nxt = cnt - 2'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl   <= '0;
      o_err <= 1'b0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      cnt   <= '0;
      i_r   <= 1'b1;
      for (int k = 0; k < TDEC_DEPTH; k++) begin
        q_d[k]   <= '0;
        q_cnt[k] <= '0;
        q_sat[k] <= 1'b0;
      end
    end else begin
      if (push) begin
        lvl       <= lvl_new;
        q_d[wp]   <= therm;
        q_cnt[wp] <= lvl_new;
        q_sat[wp] <= sat;
        wp        <= ~wp;
        if (clr) o_err <= 1'b0;
        else if (sat) o_err <= 1'b1;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt_nxt;
      // Ready comes from a flop so o_r never reaches i_r.
      i_r <= (cnt_nxt != FULL);
    end
  end

  assign o_v   = (cnt != '0);
  assign o_d   = q_d[rp];
  assign o_cnt = q_cnt[rp];
  assign o_sat = q_sat[rp];

endmodule

// File: tb/tb_base_tdec_trk.sv
// Directed bench for base_tdec_trk with immediate assertions.
// Expected values are hand-computed for dec_width=8, enc_width=4.
module tb_base_tdec_trk;

  logic       clk;
  logic       reset_n;
  logic       i_v;
  logic       i_r;
  logic [1:0] i_op;
  logic [3:0] i_d;
  logic       o_v;
  logic       o_r;
  logic [7:0] o_d;
  logic [3:0] o_cnt;
  logic       o_sat;
  logic       o_err;

  int n_asrt;
  int n_fail;

  base_tdec_trk #(
    .dec_width(8),
    .enc_width(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_v(i_v),
    .i_r(i_r),
    .i_op(i_op),
    .i_d(i_d),
    .o_v(o_v),
    .o_r(o_r),
    .o_d(o_d),
    .o_cnt(o_cnt),
    .o_sat(o_sat),
    .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic v,
                      input logic [7:0] d, input logic [3:0] c,
                      input logic s);
    chk({tag, ".o_v"}, 32'(o_v), 32'(v));
    chk({tag, ".o_d"}, 32'(o_d), 32'(d));
    chk({tag, ".o_cnt"}, 32'(o_cnt), 32'(c));
    chk({tag, ".o_sat"}, 32'(o_sat), 32'(s));
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] d);
    i_v  = 1'b1;
    i_op = op;
    i_d  = d;
  endtask

  initial begin
    n_asrt  = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    i_v     = 1'b0;
    i_op    = 2'b11;
    i_d     = 4'hf;
    o_r     = 1'b1;
    #12;
    beat("rst", 1'b0, 8'h00, 4'd0, 1'b0);
    chk("rst.i_r", 32'(i_r), 32'd1);
    chk("rst.o_err", 32'(o_err), 32'd0);
    reset_n = 1'b1;
    step();

    // idle cycles with garbage on op/data do nothing
    step();
    chk("idle.o_v", 32'(o_v), 32'd0);

    cmd(2'b00, 4'd3);
    step();
    beat("ld3", 1'b1, 8'b11100000, 4'd3, 1'b0);
    cmd(2'b00, 4'd7);
    step();
    beat("ld7", 1'b1, 8'b11111110, 4'd7, 1'b0);
    cmd(2'b01, 4'd0);
    step();
    beat("inc8", 1'b1, 8'b11111111, 4'd8, 1'b0);
    chk("inc8.o_err", 32'(o_err), 32'd0);
    step();
    beat("incsat", 1'b1, 8'b11111111, 4'd8, 1'b1);
    chk("incsat.o_err", 32'(o_err), 32'd1);
    i_v = 1'b0;
    step();
    chk("drain.o_v", 32'(o_v), 32'd0);

    cmd(2'b11, 4'd9);
    step();
    beat("clr", 1'b1, 8'h00, 4'd0, 1'b0);
    chk("clr.o_err", 32'(o_err), 32'd0);
    cmd(2'b10, 4'd0);
    step();
    beat("dec0", 1'b1, 8'h00, 4'd0, 1'b1);
    chk("dec0.o_err", 32'(o_err), 32'd1);
    cmd(2'b11, 4'd0);
    step();
    beat("clr2", 1'b1, 8'h00, 4'd0, 1'b0);
    chk("clr2.o_err", 32'(o_err), 32'd0);
    cmd(2'b00, 4'd12);
    step();
    beat("ld12", 1'b1, 8'hff, 4'd8, 1'b1);
    chk("ld12.o_err", 32'(o_err), 32'd1);
    cmd(2'b10, 4'd0);
    step();
    beat("dec7", 1'b1, 8'b11111110, 4'd7, 1'b0);
    i_v = 1'b0;
    step();

    // backpressure: two accepts fill the queue
    o_r = 1'b0;
    cmd(2'b00, 4'd1);
    step();
    beat("bp1", 1'b1, 8'b10000000, 4'd1, 1'b0);
    chk("bp1.i_r", 32'(i_r), 32'd1);
    cmd(2'b01, 4'd0);
    step();
    beat("bp2", 1'b1, 8'b10000000, 4'd1, 1'b0);
    chk("bp2.i_r", 32'(i_r), 32'd0);
    cmd(2'b01, 4'd0);
    step();
    beat("bp3", 1'b1, 8'b10000000, 4'd1, 1'b0);
    chk("bp3.i_r", 32'(i_r), 32'd0);
    step();
    beat("bp4", 1'b1, 8'b10000000, 4'd1, 1'b0);
    o_r = 1'b1;
    step();
    beat("dr1", 1'b1, 8'b11000000, 4'd2, 1'b0);
    chk("dr1.i_r", 32'(i_r), 32'd1);
    step();
    beat("dr2", 1'b1, 8'b11100000, 4'd3, 1'b0);
    chk("dr2.i_r", 32'(i_r), 32'd1);
    i_v = 1'b0;
    step();
    chk("dr3.o_v", 32'(o_v), 32'd0);

    // fill, then reset asynchronously mid-cycle
    o_r = 1'b0;
    cmd(2'b00, 4'd9);
    step();
    cmd(2'b01, 4'd0);
    step();
    i_v = 1'b0;
    chk("full.i_r", 32'(i_r), 32'd0);
    chk("full.o_err", 32'(o_err), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.o_v", 32'(o_v), 32'd0);
    chk("arst.i_r", 32'(i_r), 32'd1);
    chk("arst.o_err", 32'(o_err), 32'd0);
    chk("arst.o_d", 32'(o_d), 32'd0);
    #1;
    reset_n = 1'b1;
    o_r = 1'b1;
    cmd(2'b01, 4'd0);
    step();
    beat("postrst", 1'b1, 8'b10000000, 4'd1, 1'b0);
    i_v = 1'b0;
    step();
    chk("end.o_v", 32'(o_v), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
